// File: rtl/game_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller and board logic.
package game_pkg;

   typedef enum logic [2:0] {
      PLAY_X,
      PLAY_O,
      CHECK,
      WIN_X,
      WIN_O,
      CATS,
      ERR
   } state_t;

   localparam logic [7:0] ST_PLAY = 8'h20;
   localparam logic [7:0] ST_X    = 8'h58;
   localparam logic [7:0] ST_O    = 8'h4F;
   localparam logic [7:0] ST_CATS = 8'h43;
   localparam logic [7:0] ST_ERR  = 8'h45;

   localparam logic PLAYER_X = 1'b0;
   localparam logic PLAYER_O = 1'b1;

   localparam logic [3:0] MAX_MOVES = 4'd9;

   function automatic logic is_onehot9(input logic [8:0] v);
      return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
   endfunction

endpackage

// File: rtl/move_decode.sv
// Combinational move check: classifies a press as a valid move or an error.
module move_decode
   import game_pkg::*;
(
   input  logic       press_x,
   input  logic       press_o,
   input  logic       player,
   input  logic [8:0] sel_pos,
   input  logic [8:0] occ_pos,
   output logic       valid,
   output logic       err
);

   logic any_press;
   logic wrong_player;
   logic bad_square;

   assign any_press    = press_x | press_o;
   assign wrong_player = (player == PLAYER_X) ? press_o : press_x;
   assign bad_square   = !is_onehot9(sel_pos) || ((sel_pos & occ_pos) != 9'd0);

   // Error dominates: a press that is simultaneously valid and invalid is an error.
   assign err   = any_press & ((press_x & press_o) | wrong_player | bad_square);
   assign valid = any_press & ~err;

endmodule

// File: rtl/turn_sequencer.sv
// Game controller: press detection, turn FSM, board write strobe and status outputs.
module turn_sequencer
   import game_pkg::*;
#(
   parameter int CHECK_LAT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       buttonX,
   input  logic       buttonO,
   input  logic [8:0] sel_pos,
   input  logic [8:0] occ_pos,
   input  logic       win_x,
   input  logic       win_o,
   output logic       wr_en,
   output logic [8:0] wr_pos,
   output logic       wr_player,
   output logic       turnX,
   output logic       turnO,
   output logic [7:0] game_st,
   output logic [3:0] move_cnt
);

   state_t     state;
   state_t     state_next;
   logic       bx_q;
   logic       bo_q;
   logic       press_x;
   logic       press_o;
   logic       in_play;
   logic       cur_player;
   logic       dec_valid;
   logic       dec_err;
   logic       move_ok;
   logic       move_err;
   logic [2:0] chk_cnt;
   logic       turn_x_d;
   logic       turn_o_d;
   logic [7:0] game_st_d;

   assign press_x    = buttonX & ~bx_q;
   assign press_o    = buttonO & ~bo_q;
   assign in_play    = (state == PLAY_X) || (state == PLAY_O);
   assign cur_player = (state == PLAY_O) ? PLAYER_O : PLAYER_X;

   move_decode u_move_decode (
      .press_x (press_x),
      .press_o (press_o),
      .player  (cur_player),
      .sel_pos (sel_pos),
      .occ_pos (occ_pos),
      .valid   (dec_valid),
      .err     (dec_err)
   );

   assign move_ok  = in_play & dec_valid;
   assign move_err = in_play & dec_err;

   // NOTE: sequential state is always updated with non-blocking assignments.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= PLAY_X;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      unique case (state)
         PLAY_X, PLAY_O: begin
            if (move_err)     state_next = ERR;
            else if (move_ok) state_next = CHECK;
         end
         CHECK: begin
            if (press_x | press_o)      state_next = ERR;
            else if (chk_cnt == 3'd0) begin
               if (win_x)                      state_next = WIN_X;
               else if (win_o)                 state_next = WIN_O;
               else if (move_cnt == MAX_MOVES) state_next = CATS;
               else if (wr_player == PLAYER_X) state_next = PLAY_O;
               else                            state_next = PLAY_X;
            end
         end
         default: state_next = state;
      endcase
   end

   always_comb begin
      turn_x_d  = 1'b0;
      turn_o_d  = 1'b0;
      game_st_d = ST_PLAY;
      unique case (state_next)
         PLAY_X:  turn_x_d  = 1'b1;
         PLAY_O:  turn_o_d  = 1'b1;
         WIN_X:   game_st_d = ST_X;
         WIN_O:   game_st_d = ST_O;
         CATS:    game_st_d = ST_CATS;
         ERR:     game_st_d = ST_ERR;
         default: game_st_d = ST_PLAY;
      endcase
   end

   // NOTE: status outputs are registered from the next state so they read idle while reset is held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         turnX   <= 1'b0;
         turnO   <= 1'b0;
         game_st <= ST_PLAY;
      end else begin
         turnX   <= turn_x_d;
         turnO   <= turn_o_d;
         game_st <= game_st_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bx_q      <= 1'b0;
         bo_q      <= 1'b0;
         wr_en     <= 1'b0;
         wr_pos    <= 9'd0;
         wr_player <= PLAYER_X;
         move_cnt  <= 4'd0;
         chk_cnt   <= 3'd0;
      end else begin
         bx_q  <= buttonX;
         bo_q  <= buttonO;
         wr_en <= move_ok;
         if (move_ok) begin
            wr_pos    <= sel_pos;
            wr_player <= cur_player;
            chk_cnt   <= 3'(CHECK_LAT);
            if (move_cnt != MAX_MOVES) move_cnt <= move_cnt + 4'd1;
         end else if ((state == CHECK) && (chk_cnt != 3'd0)) begin
            chk_cnt <= chk_cnt - 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: one instance at CHECK_LAT=1, one at CHECK_LAT=3.
module tb_turn_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       buttonX;
   logic       buttonO;
   logic [8:0] sel_pos;
   logic [8:0] occ_pos;
   logic       win_x;
   logic       win_o;

   logic       wr_en_1, wr_player_1, turnX_1, turnO_1;
   logic [8:0] wr_pos_1;
   logic [7:0] game_st_1;
   logic [3:0] move_cnt_1;
   logic       wr_en_3, wr_player_3, turnX_3, turnO_3;
   logic [8:0] wr_pos_3;
   logic [7:0] game_st_3;
   logic [3:0] move_cnt_3;

   int checks = 0;
   int errors = 0;

   logic [8:0] bx_b;
   logic [8:0] bo_b;
   logic       win_en;
   int         wr_seen;

   always #5 clk = ~clk;

   turn_sequencer #(.CHECK_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .buttonX(buttonX), .buttonO(buttonO),
      .sel_pos(sel_pos), .occ_pos(occ_pos), .win_x(win_x), .win_o(win_o),
      .wr_en(wr_en_1), .wr_pos(wr_pos_1), .wr_player(wr_player_1),
      .turnX(turnX_1), .turnO(turnO_1), .game_st(game_st_1), .move_cnt(move_cnt_1)
   );

   turn_sequencer #(.CHECK_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .buttonX(buttonX), .buttonO(buttonO),
      .sel_pos(sel_pos), .occ_pos(occ_pos), .win_x(win_x), .win_o(win_o),
      .wr_en(wr_en_3), .wr_pos(wr_pos_3), .wr_player(wr_player_3),
      .turnX(turnX_3), .turnO(turnO_3), .game_st(game_st_3), .move_cnt(move_cnt_3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic has_line(input logic [8:0] b);
      logic [8:0] lines [8];
      lines = '{9'h007, 9'h038, 9'h1C0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054};
      for (int i = 0; i < 8; i++)
         if ((b & lines[i]) == lines[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic update_board();
      occ_pos = bx_b | bo_b;
      win_x   = win_en & has_line(bx_b);
      win_o   = win_en & has_line(bo_b);
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      buttonX = 1'b0;
      buttonO = 1'b0;
      sel_pos = 9'd0;
      bx_b    = 9'd0;
      bo_b    = 9'd0;
      win_en  = 1'b1;
      update_board();
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Valid move on the CHECK_LAT=1 instance; returns at edge k+2.
   task automatic move(input logic is_o, input logic [8:0] pos);
      if (is_o) buttonO = 1'b1;
      else      buttonX = 1'b1;
      sel_pos = pos;
      tick();
      check("mv_wr_en", 32'(wr_en_1), 1);
      check("mv_wr_pos", 32'(wr_pos_1), 32'(pos));
      check("mv_player", 32'(wr_player_1), 32'(is_o));
      buttonX = 1'b0;
      buttonO = 1'b0;
      sel_pos = 9'd0;
      if (is_o) bo_b = bo_b | pos;
      else      bx_b = bx_b | pos;
      update_board();
      tick();
      tick();
   endtask

   task automatic err_case(input string tag, input logic bx, input logic bo, input logic [8:0] sel);
      buttonX = bx;
      buttonO = bo;
      sel_pos = sel;
      tick();
      check({tag, "_st"}, 32'(game_st_1), 'h45);
      check({tag, "_wr"}, 32'(wr_en_1), 0);
      buttonX = 1'b0;
      buttonO = 1'b0;
      sel_pos = 9'd0;
      tick();
      check({tag, "_wr2"}, 32'(wr_en_1), 0);
      check({tag, "_st2"}, 32'(game_st_1), 'h45);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset values while reset is held
      reset   = 1'b1;
      buttonX = 1'b0;
      buttonO = 1'b0;
      sel_pos = 9'd0;
      occ_pos = 9'd0;
      win_x   = 1'b0;
      win_o   = 1'b0;
      #1;
      check("rst_turnX", 32'(turnX_1), 0);
      check("rst_turnO", 32'(turnO_1), 0);
      check("rst_game_st", 32'(game_st_1), 'h20);
      check("rst_wr_en", 32'(wr_en_1), 0);
      check("rst_move_cnt", 32'(move_cnt_1), 0);

      // Reset release and held button
      do_reset();
      check("rel_turnX", 32'(turnX_1), 1);
      check("rel_game_st", 32'(game_st_1), 'h20);
      buttonX = 1'b1;
      sel_pos = 9'h001;
      wr_seen = 0;
      tick();
      check("hold_wr_pos", 32'(wr_pos_1), 'h001);
      check("hold_player", 32'(wr_player_1), 0);
      check("hold_turnX_k", 32'(turnX_1), 0);
      check("hold_cnt", 32'(move_cnt_1), 1);
      if (wr_en_1 === 1'b1) wr_seen++;
      bx_b = 9'h001;
      update_board();
      tick();
      check("hold_turnO_k1", 32'(turnO_1), 0);
      if (wr_en_1 === 1'b1) wr_seen++;
      tick();
      check("hold_turnO_k2", 32'(turnO_1), 1);
      if (wr_en_1 === 1'b1) wr_seen++;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (wr_en_1 === 1'b1) wr_seen++;
      end
      check("hold_one_write", 32'(wr_seen), 1);
      check("hold_still_O", 32'(turnO_1), 1);
      buttonX = 1'b0;
      tick();

      // X wins on the top row
      do_reset();
      move(1'b0, 9'h001);
      move(1'b1, 9'h008);
      move(1'b0, 9'h002);
      move(1'b1, 9'h010);
      move(1'b0, 9'h004);
      check("xwin_st", 32'(game_st_1), 'h58);
      check("xwin_cnt", 32'(move_cnt_1), 5);
      check("xwin_turnX", 32'(turnX_1), 0);
      buttonO = 1'b1;
      sel_pos = 9'h100;
      tick();
      check("xwin_ign_wr", 32'(wr_en_1), 0);
      check("xwin_ign_st", 32'(game_st_1), 'h58);
      check("xwin_ign_cnt", 32'(move_cnt_1), 5);
      buttonO = 1'b0;
      sel_pos = 9'd0;

      // Cats game: nine moves, win flags held low
      do_reset();
      win_en = 1'b0;
      update_board();
      for (int i = 0; i < 9; i++) begin
         move(i[0], 9'(1 << i));
         if (i == 7) check("cats_pre_st", 32'(game_st_1), 'h20);
      end
      check("cats_st", 32'(game_st_1), 'h43);
      check("cats_cnt", 32'(move_cnt_1), 9);
      check("cats_turn", 32'({turnX_1, turnO_1}), 0);

      // Error cases, each from a fresh reset
      do_reset();
      err_case("err_wrong", 1'b0, 1'b1, 9'h001);
      do_reset();
      err_case("err_both", 1'b1, 1'b1, 9'h001);
      do_reset();
      err_case("err_2hot", 1'b1, 1'b0, 9'h003);
      do_reset();
      err_case("err_zero", 1'b1, 1'b0, 9'h000);
      do_reset();
      move(1'b0, 9'h001);
      err_case("err_occ", 1'b0, 1'b1, 9'h001);

      // CHECK_LAT=3: turn-to-turn latency
      do_reset();
      buttonX = 1'b1;
      sel_pos = 9'h010;
      tick();
      check("l3_wr_en", 32'(wr_en_3), 1);
      buttonX = 1'b0;
      sel_pos = 9'd0;
      tick();
      tick();
      tick();
      check("l3_turnO_k3", 32'(turnO_3), 0);
      tick();
      check("l3_turnO_k4", 32'(turnO_3), 1);

      // CHECK_LAT=3: press two cycles after a valid move
      do_reset();
      buttonX = 1'b1;
      sel_pos = 9'h001;
      tick();
      buttonX = 1'b0;
      sel_pos = 9'd0;
      tick();
      buttonO = 1'b1;
      sel_pos = 9'h002;
      tick();
      check("l3_chk_err_st", 32'(game_st_3), 'h45);
      check("l3_chk_err_turn", 32'(turnO_3), 0);
      buttonO = 1'b0;
      sel_pos = 9'd0;

      // Reset during the write strobe
      do_reset();
      buttonX = 1'b1;
      sel_pos = 9'h001;
      tick();
      check("rw_wr_en", 32'(wr_en_3), 1);
      buttonX = 1'b0;
      sel_pos = 9'd0;
      reset = 1'b1;
      #1;
      check("rw_wr_en_clr", 32'(wr_en_3), 0);
      check("rw_wr_pos_clr", 32'(wr_pos_3), 0);
      check("rw_cnt_clr", 32'(move_cnt_3), 0);
      check("rw_st_clr", 32'(game_st_3), 'h20);
      reset = 1'b0;
      tick();
      check("rw_turnX", 32'(turnX_3), 1);

      // Reset mid-CHECK
      buttonX = 1'b1;
      sel_pos = 9'h001;
      tick();
      buttonX = 1'b0;
      sel_pos = 9'd0;
      tick();
      check("rc_turnX_in_chk", 32'(turnX_3), 0);
      reset = 1'b1;
      #1;
      check("rc_cnt_clr", 32'(move_cnt_3), 0);
      check("rc_turn_clr", 32'({turnX_3, turnO_3}), 0);
      reset = 1'b0;
      tick();
      check("rc_turnX", 32'(turnX_3), 1);
      check("rc_st", 32'(game_st_3), 'h20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Central controller for the tic-tac-toe game. Detects button presses, decides whose turn it is and validates each move. Issues a single-cycle write into the board register datapath, then waits for the win checker and sequences the game to the next turn or to a terminal state. Owns `turnX`, `turnO` and the ASCII `game_st` status byte.

## Interface
- `CHECK_LAT`, default 1: cycles after the board write before `win_x`/`win_o` are valid; legal range 1..7.

Ports:
- `clk` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-high; game held in reset while 1.
- `buttonX` input 1: X player button, level, already synchronous to `clk`.
- `buttonO` input 1: O player button, level, already synchronous to `clk`.
- `sel_pos` input 9: selected square; must be one-hot at the press.
- `occ_pos` input 9: square occupied (either player), from the board.
- `win_x` input 1: board has an X line, from the win checker.
- `win_o` input 1: board has an O line, from the win checker.
- `wr_en` output 1: one-cycle board write strobe.
- `wr_pos` output 9: one-hot square to write; equals `sel_pos` captured at the press.
- `wr_player` output 1: 0 = X, 1 = O.
- `turnX` output 1: X to move.
- `turnO` output 1: O to move.
- `game_st` output 8: ASCII status.
- `move_cnt` output 4: committed moves, 0..9.

## Operation
- Press detection:
  - Registered copies `bx_q` and `bo_q` of the buttons.
  - `pressX = buttonX & ~bx_q`; `pressO` likewise.
  - Holding a button produces exactly one press.
- States: `PLAY_X`, `PLAY_O`, `CHECK`, `WIN_X`, `WIN_O`, `CATS`, `ERR`.
- Reset: state `PLAY_X` on release, `move_cnt`=0, `bx_q`=`bo_q`=0, `wr_en`=0, `wr_pos`=0, `wr_player`=0. While `reset`=1: `turnX`=`turnO`=0, `game_st`=8'h20 (space).
- `PLAY_X`/`PLAY_O`, checked in a cycle with any press:
  - Error if any of:
    - both `pressX` and `pressO`;
    - press by the player not on turn;
    - `sel_pos` not one-hot (zero or ≥2 bits);
    - `(sel_pos & occ_pos) != 0`.
  - Error goes to `ERR`.
  - Otherwise the move is valid:
    - latch `wr_pos`=`sel_pos` and `wr_player`;
    - pulse `wr_en`;
    - `move_cnt`+1;
    - go to `CHECK`.
- `CHECK`:
  - Held for CHECK_LAT+1 cycles by a 3-bit down-counter.
  - Any press in `CHECK` goes to `ERR` (played out of turn).
  - At exit, by priority: `win_x` goes to `WIN_X`; else `win_o` goes to `WIN_O`; else `move_cnt`==9 goes to `CATS`; else the other player's `PLAY_*`.
- Terminal states `WIN_X`, `WIN_O`, `CATS`, `ERR`: sticky until `reset`; presses ignored; `wr_en` stays 0.
- Outputs by state:
  - `turnX`=1 only in `PLAY_X`; `turnO`=1 only in `PLAY_O`.
  - `game_st`: 8'h20 in play states; 'X' 8'h58, 'O' 8'h4F, 'C' 8'h43, 'E' 8'h45 in the terminal states.
- `move_cnt` saturates at 9; it never wraps.

## Timing
- A press is sampled at edge k (button 0 at edge k-1, 1 at edge k).
- At edge k: state becomes `CHECK`, and `wr_en`=1 for exactly the cycle between edges k and k+1.
- Board updates at edge k+1. Win flags are sampled at edge k+1+CHECK_LAT, where the next state is entered. Minimum turn-to-turn latency is 2+CHECK_LAT cycles.
- `turnX`/`turnO` are 0 throughout `CHECK`.
- `game_st` and turn outputs are registered or decoded from registered state only; no combinational input-to-output path.
- Reset asserted mid-`CHECK` or during `wr_en` clears all outputs immediately (asynchronous). The write is dropped.
- Simultaneous invalid and valid conditions: error wins.

## Structure
- Package `game_pkg`:
  - state enum;
  - ASCII constants `ST_PLAY`, `ST_X`, `ST_O`, `ST_CATS`, `ST_ERR`;
  - player encoding `PLAYER_X`=0, `PLAYER_O`=1;
  - `MAX_MOVES`=9.
- Sub-module `move_decode`, combinational, shared with the board's move-validity logic:
  - inputs: press pair, current player, `sel_pos`, `occ_pos`;
  - outputs: `valid`, `err`.
- FSM, `CHECK` counter, press registers and `move_cnt` stay in `turn_sequencer`.

## Test plan
- **Reset release:** after reset → `turnX`=1, `game_st`=8'h20. Hold `buttonX` 5 cycles with `sel_pos`=9'h001 → exactly one `wr_en`, `wr_pos`=9'h001, `wr_player`=0, then `turnO`=1 at edge k+2.
- **X wins:** X row 0,1,2 / O 3,4 alternating; model `win_x` from the board → `WIN_X`, `game_st`=8'h58, `move_cnt`=5, later presses ignored.
- **Cats game:** 9 valid alternating moves, win flags held 0 → `game_st`=8'h43 after the 9th check, `move_cnt`=9.
- **Errors, each from a fresh reset:**
  - `buttonO` press in `PLAY_X`;
  - both pressed in the same cycle;
  - `sel_pos`=9'h003;
  - press on an occupied square.
  - Each → `game_st`=8'h45 next cycle, `wr_en` never asserted.
- **Press in `CHECK`:** `CHECK_LAT`=3, second press 2 cycles after a valid move → `ERR`. Reset asserted mid-`CHECK` → outputs cleared immediately, `PLAY_X` after release.
